vga_rect_fill: RTL

- Upstream pixel-write generator for the VGA frame-buffer top level.
- Accepts rectangle-fill commands (corners plus 2-bit colour) over a valid/ready handshake.
- Clips each command to the active area, then walks it in raster order.
- Emits one pixel write per grant on the frame buffer's `we`/`wr_gnt` interface, whose `color`/`addr_x`/`addr_y`/`we` inputs it drives directly.

---
 rtl/vga_rect_fill.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/vga_rect_fill.sv
// vga_rect_fill: rectangle-fill pixel-write generator for the VGA frame buffer.
// Accepts a fill command (inclusive corners + 2-bit colour) over valid/ready,
// clips it to the active area and walks it in raster order, issuing one
// pixel write per frame-buffer grant.
//
// Ports:
//   clk_i        single clock (frame-buffer write domain)
//   arstn_i      asynchronous active-low reset, synchronous release
//   cmd_valid_i  command valid
//   cmd_ready_o  block can accept a command (IDLE only)
//   cmd_x0_i/y0_i, cmd_x1_i/y1_i  inclusive corners
//   cmd_color_i  0 black, 1 white, 2 blue, 3 green
//   abort_i      terminate the current fill (FILL only)
//   we_o         pixel write request
//   wr_gnt_i     write accepted by the frame buffer
//   addr_x_o/addr_y_o/color_o  pixel being written
//   busy_o       not IDLE
//   done_o       one-cycle pulse at the end of every accepted command
//   aborted_o    last command was ended by abort
//   pix_cnt_o    writes granted for the current/last command
module vga_rect_fill #(
  parameter int unsigned COORD_W  = 11,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned CNT_W    = 22
) (
  input  logic               clk_i,
  input  logic               arstn_i,
  input  logic               cmd_valid_i,
  output logic               cmd_ready_o,
  input  logic [COORD_W-1:0] cmd_x0_i,
  input  logic [COORD_W-1:0] cmd_y0_i,
  input  logic [COORD_W-1:0] cmd_x1_i,
  input  logic [COORD_W-1:0] cmd_y1_i,
  input  logic [1:0]         cmd_color_i,
  input  logic               abort_i,
  output logic               we_o,
  input  logic               wr_gnt_i,
  output logic [COORD_W-1:0] addr_x_o,
  output logic [COORD_W-1:0] addr_y_o,
  output logic [1:0]         color_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               aborted_o,
  output logic [CNT_W-1:0]   pix_cnt_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_ACTIVE - 1);

  logic [1:0]         state_q,   state_d;
  logic [COORD_W-1:0] x_q,       x_d;
  logic [COORD_W-1:0] y_q,       y_d;
  logic [COORD_W-1:0] x0_q,      x0_d;
  logic [COORD_W-1:0] xe_q,      xe_d;
  logic [COORD_W-1:0] ye_q,      ye_d;
  logic [1:0]         color_q,   color_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic               aborted_q, aborted_d;

  // Clipped inclusive end corner of the incoming command.
  logic [COORD_W-1:0] xe_clip;
  logic [COORD_W-1:0] ye_clip;
  logic               cmd_empty;

  assign xe_clip   = (cmd_x1_i > X_LAST) ? X_LAST : cmd_x1_i;
  assign ye_clip   = (cmd_y1_i > Y_LAST) ? Y_LAST : cmd_y1_i;
  // Also covers x0/y0 lying entirely outside the active area.
  assign cmd_empty = (cmd_x0_i > xe_clip) || (cmd_y0_i > ye_clip);

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      x0_q      <= '0;
      xe_q      <= '0;
      ye_q      <= '0;
      color_q   <= '0;
      cnt_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      x0_q      <= x0_d;
      xe_q      <= xe_d;
      ye_q      <= ye_d;
      color_q   <= color_d;
      cnt_q     <= cnt_d;
      aborted_q <= aborted_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    x0_d      = x0_q;
    xe_d      = xe_q;
    ye_d      = ye_q;
    color_d   = color_q;
    cnt_d     = cnt_q;
    aborted_d = aborted_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          color_d   = cmd_color_i;
          x0_d      = cmd_x0_i;
          xe_d      = xe_clip;
          ye_d      = ye_clip;
          cnt_d     = '0;
          aborted_d = 1'b0;
          if (cmd_empty) begin
            state_d = ST_DONE;
          end else begin
            x_d     = cmd_x0_i;
            y_d     = cmd_y0_i;
            state_d = ST_FILL;
          end
        end
      end

      ST_FILL: begin
        if (wr_gnt_i) begin
          if (cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if ((x_q == xe_q) && (y_q == ye_q)) begin
            state_d = ST_DONE;
          end else if (x_q == xe_q) begin
            x_d = x0_q;
            y_d = y_q + COORD_W'(1);
          end else begin
            x_d = x_q + COORD_W'(1);
          end
        end
        // A grant in the abort cycle still counts and is the final write.
        if (abort_i) begin
          state_d   = ST_DONE;
          aborted_d = 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status and handshake decode straight from the state register.
  assign cmd_ready_o = (state_q == ST_IDLE);
  assign we_o        = (state_q == ST_FILL);
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);

  assign addr_x_o  = x_q;
  assign addr_y_o  = y_q;
  assign color_o   = color_q;
  assign pix_cnt_o = cnt_q;
  assign aborted_o = aborted_q;

endmodule
